// File: rtl/steer_pkg.sv
// Shared types and widths for the steering PD controller and its PWM back end.
package steer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SEARCH = 2'd3
  } state_e;

  localparam int PWM_BITS = 10;
  localparam int CX_W     = 11;
  localparam int ERR_W    = 12;
  localparam int DERIV_W  = 13;
  localparam int CALC_W   = 24;

  localparam logic signed [CALC_W-1:0] DUTY_MAX_S = CALC_W'((1 << PWM_BITS) - 1);

  function automatic logic [PWM_BITS-1:0] clamp_duty(input logic signed [CALC_W-1:0] v);
    if (v[CALC_W-1]) return '0;
    if (v > DUTY_MAX_S) return '1;
    return v[PWM_BITS-1:0];
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM; the duty is latched only at the 1023->0 wrap so a period never glitches.
module pwm_gen
  import steer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] latch_q, latch_d;

  always_comb begin
    cnt_d   = cnt_q + PWM_BITS'(1);
    latch_d = latch_q;
    if (&cnt_q) latch_d = duty_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      latch_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

  assign pwm_o = (cnt_q < latch_q);

endmodule

// File: rtl/steer_pd_ctrl.sv
// Line-following steering: PD correction on centroid error, lost-line hold/search FSM,
// two-stage duty pipeline feeding glitch-free PWM.
// state  | meaning
// IDLE   | drive disabled, duties 0
// TRACK  | line seen, duties from PD law
// HOLD   | line lost, last TRACK duties held
// SEARCH | lost too long, spin toward side of last error
module steer_pd_ctrl
  import steer_pkg::*;
#(
  parameter int IMG_W       = 640,
  parameter int KP          = 8,
  parameter int KD          = 4,
  parameter int GAIN_SHIFT  = 3,
  parameter int BASE_DUTY   = 600,
  parameter int SEARCH_DUTY = 400,
  parameter int LOST_HOLD   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                upd,
  input  logic [CX_W-1:0]     centroid_x,
  input  logic                line_valid,
  input  logic                line_lost,
  output logic [PWM_BITS-1:0] duty_left,
  output logic [PWM_BITS-1:0] duty_right,
  output logic                pwm_left,
  output logic                pwm_right,
  output logic                cmd_valid,
  output logic [1:0]          state
);

  localparam logic signed [ERR_W-1:0]  SETPOINT = ERR_W'(IMG_W / 2);
  localparam logic signed [CALC_W-1:0] KP_S     = CALC_W'(KP);
  localparam logic signed [CALC_W-1:0] KD_S     = CALC_W'(KD);
  localparam logic signed [CALC_W-1:0] BASE_S   = CALC_W'(BASE_DUTY);
  localparam logic [PWM_BITS-1:0]      SEARCH_D = PWM_BITS'(SEARCH_DUTY);
  localparam int                       LC_W     = $clog2(LOST_HOLD + 1);
  localparam logic [LC_W-1:0]          LOST_MAX = LC_W'(LOST_HOLD);

  state_e                    state_q, state_d;
  logic signed [ERR_W-1:0]   prev_err_q, prev_err_d;
  logic signed [ERR_W-1:0]   s1_err_q, s1_err_d;
  logic signed [DERIV_W-1:0] s1_deriv_q, s1_deriv_d;
  logic [LC_W-1:0]           lost_cnt_q, lost_cnt_d;
  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_search_q, s1_search_d;
  logic [PWM_BITS-1:0]       duty_l_q, duty_l_d;
  logic [PWM_BITS-1:0]       duty_r_q, duty_r_d;
  logic                      cmd_valid_q, cmd_valid_d;

  logic                      upd_valid, upd_lost;
  logic signed [ERR_W-1:0]   err_now;
  logic signed [DERIV_W-1:0] deriv_now;
  logic [LC_W-1:0]           lost_inc;
  logic signed [CALC_W-1:0]  err_w, deriv_w, corr, sum_l, sum_r;

  // lost wins over valid when both flags arrive together
  assign upd_lost  = upd & line_lost;
  assign upd_valid = upd & line_valid & ~line_lost;

  assign err_now   = $signed({1'b0, centroid_x}) - SETPOINT;
  assign deriv_now = {err_now[ERR_W-1], err_now} - {prev_err_q[ERR_W-1], prev_err_q};
  assign lost_inc  = (lost_cnt_q == LOST_MAX) ? lost_cnt_q : lost_cnt_q + LC_W'(1);

  always_comb begin
    state_d     = state_q;
    prev_err_d  = prev_err_q;
    lost_cnt_d  = lost_cnt_q;
    s1_valid_d  = 1'b0;
    s1_search_d = 1'b0;
    s1_err_d    = s1_err_q;
    s1_deriv_d  = s1_deriv_q;
    if (!en) begin
      state_d    = ST_IDLE;
      lost_cnt_d = '0;
    end else if (upd_valid) begin
      state_d    = ST_TRACK;
      lost_cnt_d = '0;
      prev_err_d = err_now;
      s1_valid_d = 1'b1;
      s1_err_d   = err_now;
      s1_deriv_d = (state_q == ST_TRACK) ? deriv_now : '0;
    end else if (upd_lost && (state_q == ST_TRACK || state_q == ST_HOLD)) begin
      lost_cnt_d = lost_inc;
      if (lost_inc >= LOST_MAX) begin
        state_d     = ST_SEARCH;
        s1_valid_d  = 1'b1;
        s1_search_d = 1'b1;
        s1_err_d    = prev_err_q;
      end else begin
        state_d = ST_HOLD;
      end
    end
  end

  assign err_w   = {{(CALC_W-ERR_W){s1_err_q[ERR_W-1]}}, s1_err_q};
  assign deriv_w = {{(CALC_W-DERIV_W){s1_deriv_q[DERIV_W-1]}}, s1_deriv_q};
  assign corr    = (KP_S * err_w + KD_S * deriv_w) >>> GAIN_SHIFT;
  assign sum_l   = BASE_S + corr;
  assign sum_r   = BASE_S - corr;

  always_comb begin
    duty_l_d    = duty_l_q;
    duty_r_d    = duty_r_q;
    cmd_valid_d = 1'b0;
    if (!en) begin
      duty_l_d = '0;
      duty_r_d = '0;
    end else if (s1_valid_q) begin
      cmd_valid_d = 1'b1;
      if (s1_search_q) begin
        duty_l_d = s1_err_q[ERR_W-1] ? '0 : SEARCH_D;
        duty_r_d = s1_err_q[ERR_W-1] ? SEARCH_D : '0;
      end else begin
        duty_l_d = clamp_duty(sum_l);
        duty_r_d = clamp_duty(sum_r);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prev_err_q  <= '0;
      lost_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_search_q <= 1'b0;
      s1_err_q    <= '0;
      s1_deriv_q  <= '0;
      duty_l_q    <= '0;
      duty_r_q    <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_err_q  <= prev_err_d;
      lost_cnt_q  <= lost_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_search_q <= s1_search_d;
      s1_err_q    <= s1_err_d;
      s1_deriv_q  <= s1_deriv_d;
      duty_l_q    <= duty_l_d;
      duty_r_q    <= duty_r_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign duty_left  = duty_l_q;
  assign duty_right = duty_r_q;
  assign cmd_valid  = cmd_valid_q;
  assign state      = state_q;

  pwm_gen u_pwm_left (
    .clk    (clk),
    .rst    (rst),
    .duty_i (duty_l_q),
    .pwm_o  (pwm_left)
  );

  pwm_gen u_pwm_right (
    .clk    (clk),
    .rst    (rst),
    .duty_i (duty_r_q),
    .pwm_o  (pwm_right)
  );

endmodule

// File: tb/tb_steer_pd_ctrl.sv
// Directed + randomized bench for steer_pd_ctrl against an update-level behavioural model.
module tb_steer_pd_ctrl;

  localparam int IMG_W       = 640;
  localparam int KP          = 8;
  localparam int KD          = 4;
  localparam int GAIN_SHIFT  = 3;
  localparam int BASE_DUTY   = 600;
  localparam int SEARCH_DUTY = 400;
  localparam int LOST_HOLD   = 8;

  localparam int S_IDLE   = 0;
  localparam int S_TRACK  = 1;
  localparam int S_HOLD   = 2;
  localparam int S_SEARCH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        upd = 1'b0;
  logic [10:0] centroid_x = '0;
  logic        line_valid = 1'b0;
  logic        line_lost = 1'b0;
  logic [9:0]  duty_left, duty_right;
  logic        pwm_left, pwm_right, cmd_valid;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail = 0;

  int m_state, m_prev, m_lost, m_dl, m_dr;

  always #5 clk = ~clk;

  steer_pd_ctrl #(
    .IMG_W       (IMG_W),
    .KP          (KP),
    .KD          (KD),
    .GAIN_SHIFT  (GAIN_SHIFT),
    .BASE_DUTY   (BASE_DUTY),
    .SEARCH_DUTY (SEARCH_DUTY),
    .LOST_HOLD   (LOST_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .upd        (upd),
    .centroid_x (centroid_x),
    .line_valid (line_valid),
    .line_lost  (line_lost),
    .duty_left  (duty_left),
    .duty_right (duty_right),
    .pwm_left   (pwm_left),
    .pwm_right  (pwm_right),
    .cmd_valid  (cmd_valid),
    .state      (state)
  );

  // PWM period bookkeeping: cycles since reset release, 1024 per period
  logic [9:0] ref_cnt;
  int win, hi_l, hi_r;
  int hist_l[8];
  int hist_r[8];

  always @(posedge clk or posedge rst) begin
    if (rst) ref_cnt <= '0;
    else     ref_cnt <= ref_cnt + 10'd1;
  end

  always @(negedge clk) begin
    if (rst) begin
      win = 0; hi_l = 0; hi_r = 0;
    end else begin
      if (pwm_left)  hi_l++;
      if (pwm_right) hi_r++;
      if (ref_cnt == 10'd1023) begin
        if (win < 8) begin
          hist_l[win] = hi_l;
          hist_r[win] = hi_r;
        end
        win++;
        hi_l = 0;
        hi_r = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int calc_corr(input int e, input int d);
    return (KP * e + KD * d) >>> GAIN_SHIFT;
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  // kind: 0 valid, 1 lost, 2 valid+lost, 3 neither flag
  task automatic model_upd(input int kind, input int cx, output bit exp_cmd);
    int e, d, c;
    exp_cmd = 1'b0;
    if (kind == 0) begin
      e = cx - IMG_W / 2;
      d = (m_state == S_TRACK) ? e - m_prev : 0;
      c = calc_corr(e, d);
      m_prev = e;
      m_state = S_TRACK;
      m_lost = 0;
      m_dl = clamp(BASE_DUTY + c);
      m_dr = clamp(BASE_DUTY - c);
      exp_cmd = 1'b1;
    end else if (kind == 1 || kind == 2) begin
      if (m_state == S_TRACK || m_state == S_HOLD) begin
        m_lost++;
        if (m_lost >= LOST_HOLD) begin
          m_state = S_SEARCH;
          exp_cmd = 1'b1;
          if (m_prev >= 0) begin m_dl = SEARCH_DUTY; m_dr = 0; end
          else             begin m_dl = 0; m_dr = SEARCH_DUTY; end
        end else begin
          m_state = S_HOLD;
        end
      end
    end
  endtask

  task automatic do_upd(input string tag, input int kind, input int cx);
    bit exp_cmd;
    @(negedge clk);
    upd = 1'b1;
    centroid_x = cx[10:0];
    line_valid = (kind == 0 || kind == 2);
    line_lost  = (kind == 1 || kind == 2);
    model_upd(kind, cx, exp_cmd);
    @(negedge clk);
    upd = 1'b0;
    centroid_x = 11'($urandom_range(0, 2047));
    line_valid = 1'($urandom_range(0, 1));
    line_lost  = 1'($urandom_range(0, 1));
    check({tag, ".state"}, state, m_state);
    check({tag, ".cmd_early"}, cmd_valid, 0);
    @(negedge clk);
    check({tag, ".cmd"}, cmd_valid, exp_cmd);
    check({tag, ".duty_l"}, duty_left, m_dl);
    check({tag, ".duty_r"}, duty_right, m_dr);
  endtask

  task automatic en_pulse(input string tag, input bit with_upd);
    @(negedge clk);
    en = 1'b0;
    if (with_upd) begin
      upd = 1'b1;
      line_valid = 1'b1;
      line_lost = 1'b0;
      centroid_x = 11'($urandom_range(0, 1023));
    end
    @(negedge clk);
    en = 1'b1;
    upd = 1'b0;
    line_valid = 1'b0;
    m_state = S_IDLE; m_dl = 0; m_dr = 0; m_lost = 0;
    check({tag, ".state"}, state, m_state);
    check({tag, ".duty_l"}, duty_left, 0);
    check({tag, ".duty_r"}, duty_right, 0);
    @(negedge clk);
    check({tag, ".cmd"}, cmd_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; upd = 1'b0;
    line_valid = 1'b0; line_lost = 1'b0; centroid_x = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    m_state = S_IDLE; m_prev = 0; m_lost = 0; m_dl = 0; m_dr = 0;
  endtask

  initial begin
    int r, n, guard;
    bit seen;

    // reset state
    do_reset();
    @(negedge clk);
    check("rst.state", state, S_IDLE);
    check("rst.duty_l", duty_left, 0);
    check("rst.duty_r", duty_right, 0);
    check("rst.cmd", cmd_valid, 0);
    check("rst.pwm_l", pwm_left, 0);
    check("rst.pwm_r", pwm_right, 0);
    en = 1'b1;

    // centred line, then offset line from a fresh start
    do_upd("c320", 0, 320);
    check("c320.const_l", duty_left, 600);
    en_pulse("idle1", 1'b0);
    do_upd("c400", 0, 400);
    check("c400.const_l", duty_left, 680);
    check("c400.const_r", duty_right, 520);

    // clamping on a large swing
    en_pulse("idle2", 1'b0);
    do_upd("c639", 0, 639);
    do_upd("c0", 0, 0);
    check("c0.clamp_l", duty_left, 0);
    check("c0.clamp_r", duty_right, 1023);

    // lost sequence with positive last error; 2nd update carries both flags
    do_upd("pos", 0, 400);
    for (int i = 0; i < LOST_HOLD; i++)
      do_upd($sformatf("lost%0d", i + 1), (i == 1) ? 2 : 1, 0);
    check("search.state", state, S_SEARCH);
    check("search.duty_l", duty_left, 400);
    check("search.duty_r", duty_right, 0);
    do_upd("search_lost", 1, 0);
    do_upd("search_exit", 0, 320);
    check("search_exit.state", state, S_TRACK);

    // lost sequence with negative last error
    do_upd("neg", 0, 200);
    for (int i = 0; i < LOST_HOLD; i++) do_upd("nlost", 1, 0);
    check("nsearch.duty_l", duty_left, 0);
    check("nsearch.duty_r", duty_right, 400);
    do_upd("none_flags", 3, 900);

    // enable dropped while an update is in flight
    do_upd("pre_drop", 0, 500);
    @(negedge clk);
    upd = 1'b1; line_valid = 1'b1; line_lost = 1'b0; centroid_x = 11'd100;
    @(negedge clk);
    upd = 1'b0; line_valid = 1'b0; en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    m_state = S_IDLE; m_dl = 0; m_dr = 0; m_lost = 0;
    check("drop.state", state, S_IDLE);
    check("drop.duty_l", duty_left, 0);
    check("drop.duty_r", duty_right, 0);
    check("drop.cmd", cmd_valid, 0);
    @(negedge clk);
    check("drop.cmd_late", cmd_valid, 0);
    do_upd("post_drop", 0, 350);
    en_pulse("en_with_upd", 1'b1);

    // reset in the middle of a computation
    @(negedge clk);
    upd = 1'b1; line_valid = 1'b1; centroid_x = 11'd400;
    @(negedge clk);
    upd = 1'b0; line_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    m_state = S_IDLE; m_prev = 0; m_lost = 0; m_dl = 0; m_dr = 0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) seen = 1'b1;
    end
    check("midrst.no_cmd", seen, 0);
    check("midrst.state", state, S_IDLE);
    check("midrst.duty_l", duty_left, 0);

    // randomized updates against the model
    en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        do_upd("rnd_valid", 0, $urandom_range(0, 2047));
      end else if (r <= 7) begin
        n = $urandom_range(1, 10);
        for (int j = 0; j < n; j++)
          do_upd("rnd_lost", ($urandom_range(0, 3) == 0) ? 2 : 1, $urandom_range(0, 2047));
      end else if (r == 8) begin
        do_upd("rnd_none", 3, $urandom_range(0, 2047));
      end else begin
        en_pulse("rnd_en", 1'($urandom_range(0, 1)));
      end
    end

    // PWM: duty_right steps 600 -> 100 in the middle of period 1
    do_reset();
    @(negedge clk);
    en = 1'b1;
    do_upd("pwm_base", 0, 320);
    guard = 0;
    while (!(win == 1 && ref_cnt == 10'd500) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("pwm.sync_timeout", guard < 4000, 1);
    do_upd("pwm_lost", 1, 0);
    do_upd("pwm_step", 0, 820);
    guard = 0;
    while (win < 3 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("pwm.end_timeout", guard < 4000, 1);
    check("pwm.r_p0", hist_r[0], 0);
    check("pwm.r_p1", hist_r[1], 600);
    check("pwm.r_p2", hist_r[2], 100);
    check("pwm.l_p1", hist_l[1], 600);
    check("pwm.l_p2", hist_l[2], 1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
